// File: rtl/shift_subtract_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// Results and div_by_zero hold from done until the next accepted start.
module shift_subtract_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // state | meaning
  // IDLE  | waiting for start; results held
  // RUN   | one restoring step per cycle, cnt counts down to 0
  // DONE  | single-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  // Partial remainder is always < divisor after a step, so its top bit is stored
  // implicitly as zero; the shifted trial value t keeps the full WIDTH+1 bits.
  logic [WIDTH:0]   t;
  logic             ge;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    t       = {r_q, q_q[WIDTH-1]};
    ge      = (t >= {1'b0, d_q});

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            state_d = RUN;
            q_d     = dividend;
            r_d     = '0;
            d_d     = divisor;
            cnt_d   = CW'(WIDTH - 1);
            dbz_d   = 1'b0;
          end else begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
        end
      end
      RUN: begin
        q_d = {q_q[WIDTH-2:0], ge};
        r_d = ge ? WIDTH'(t - {1'b0, d_q}) : t[WIDTH-1:0];
        if (cnt_q == '0) begin
          state_d = DONE;
          quot_d  = q_d;
          rem_d   = r_d;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
